// File: rtl/ag32gbd_cart_bus_sync.sv
// ---------------------------------------------------------------------------
// ag32gbd_cart_bus_sync
//
// Front end for the Game Boy cartridge bus. The asynchronous cart pins are
// brought into the sys_clock domain, strobes are glitch filtered, and pin
// activity is turned into clean single-cycle events (write commit, read
// start, read address change, read end) that carry a stable address/data.
//
// Ports:
//   sys_clock, resetn       system clock, async active-low reset
//   cart_a, cart_d          raw cart address / data pins (sampled only)
//   cart_nWR/nRD/nCS        raw cart strobes and SRAM chip select
//   err_clr                 one-cycle pulse clearing the sticky error flags
//   wr_strobe               pulse: a cart write committed
//   wr_addr/wr_data/wr_cs   captured address, data and ~nCS of that write
//   rd_start                pulse: a read was accepted, rd_addr valid
//   rd_addr_chg             pulse: address changed and settled mid-read
//   rd_end                  pulse: the read was released
//   rd_active               high from rd_start through rd_end
//   rd_addr/rd_cs           address and ~nCS of the current read
//   err_collision           sticky: nWR and nRD seen low together
//   err_glitch              sticky: a strobe shorter than SETTLE_CYCLES
// ---------------------------------------------------------------------------
module ag32gbd_cart_bus_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic        sys_clock,
  input  logic        resetn,
  input  logic [15:0] cart_a,
  input  logic [7:0]  cart_d,
  input  logic        cart_nWR,
  input  logic        cart_nRD,
  input  logic        cart_nCS,
  input  logic        err_clr,
  output logic        wr_strobe,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_cs,
  output logic        rd_start,
  output logic        rd_addr_chg,
  output logic        rd_end,
  output logic        rd_active,
  output logic [15:0] rd_addr,
  output logic        rd_cs,
  output logic        err_collision,
  output logic        err_glitch
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETTLE,
    ST_WR_HOLD,
    ST_RD_SETTLE,
    ST_RD_ACTIVE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] SETTLE_FULL = 4'(SETTLE_CYCLES);
  // With a one-cycle settle the strobe is accepted straight from IDLE.
  localparam bit         SETTLE_NOW  = (SETTLE_CYCLES == 1);

  // Synchroniser chains for the controls, matching plain delay lines for A/D
  logic [SYNC_STAGES-1:0]       nwr_sync_q, nwr_sync_d;
  logic [SYNC_STAGES-1:0]       nrd_sync_q, nrd_sync_d;
  logic [SYNC_STAGES-1:0]       ncs_sync_q, ncs_sync_d;
  logic [SYNC_STAGES-1:0][15:0] a_dly_q, a_dly_d;
  logic [SYNC_STAGES-1:0][7:0]  d_dly_q, d_dly_d;

  logic        nwr_s, nrd_s, ncs_s;
  logic [15:0] a_s;
  logic [7:0]  d_s;

  state_t      state_q, state_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d, settle_inc;
  logic [3:0]  chg_cnt_q, chg_cnt_d;
  logic [15:0] cand_q, cand_d;
  logic [15:0] hold_addr_q, hold_addr_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_cs_q, hold_cs_d;

  logic        wr_strobe_q, wr_strobe_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_cs_q, wr_cs_d;
  logic        rd_start_q, rd_start_d;
  logic        rd_addr_chg_q, rd_addr_chg_d;
  logic        rd_end_q, rd_end_d;
  logic        rd_active_q, rd_active_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic        rd_cs_q, rd_cs_d;
  logic        err_collision_q, err_collision_d;
  logic        err_glitch_q, err_glitch_d;

  logic        coll_set, glitch_set, rd_accept, rd_release, hold_load;

  // Shift the raw pins into the synchroniser / alignment chains
  always_comb begin
    nwr_sync_d = {nwr_sync_q[SYNC_STAGES-2:0], cart_nWR};
    nrd_sync_d = {nrd_sync_q[SYNC_STAGES-2:0], cart_nRD};
    ncs_sync_d = {ncs_sync_q[SYNC_STAGES-2:0], cart_nCS};
    a_dly_d    = {a_dly_q[SYNC_STAGES-2:0], cart_a};
    d_dly_d    = {d_dly_q[SYNC_STAGES-2:0], cart_d};
  end

  assign nwr_s = nwr_sync_q[SYNC_STAGES-1];
  assign nrd_s = nrd_sync_q[SYNC_STAGES-1];
  assign ncs_s = ncs_sync_q[SYNC_STAGES-1];
  assign a_s   = a_dly_q[SYNC_STAGES-1];
  assign d_s   = d_dly_q[SYNC_STAGES-1];

  assign settle_inc = (settle_cnt_q == 4'hF) ? settle_cnt_q : settle_cnt_q + 4'd1;

  // Next-state and event logic
  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_inc;
    chg_cnt_d     = chg_cnt_q;
    cand_d        = cand_q;
    hold_addr_d   = hold_addr_q;
    hold_data_d   = hold_data_q;
    hold_cs_d     = hold_cs_q;
    wr_strobe_d   = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_cs_d       = wr_cs_q;
    rd_start_d    = 1'b0;
    rd_addr_chg_d = 1'b0;
    rd_end_d      = 1'b0;
    rd_active_d   = rd_active_q;
    rd_addr_d     = rd_addr_q;
    rd_cs_d       = rd_cs_q;
    coll_set      = 1'b0;
    glitch_set    = 1'b0;
    rd_accept     = 1'b0;
    rd_release    = 1'b0;
    hold_load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!nwr_s) begin
          coll_set  = !nrd_s;
          hold_load = 1'b1;
          state_d   = SETTLE_NOW ? ST_WR_HOLD : ST_WR_SETTLE;
        end else if (!nrd_s) begin
          if (SETTLE_NOW) begin
            rd_accept = 1'b1;
            state_d   = ST_RD_ACTIVE;
          end else begin
            state_d = ST_RD_SETTLE;
          end
        end
      end
      ST_WR_SETTLE: begin
        if (nwr_s) begin
          glitch_set = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          hold_load = 1'b1;
          if (settle_inc == SETTLE_LAST) begin
            state_d = ST_WR_HOLD;
          end
        end
      end
      ST_WR_HOLD: begin
        // Commit what was sampled on the last cycle nWR was still low
        if (nwr_s) begin
          wr_strobe_d = 1'b1;
          wr_addr_d   = hold_addr_q;
          wr_data_d   = hold_data_q;
          wr_cs_d     = hold_cs_q;
          state_d     = ST_IDLE;
        end else begin
          hold_load = 1'b1;
        end
      end
      ST_RD_SETTLE: begin
        if (nrd_s) begin
          glitch_set = 1'b1;
          state_d    = ST_IDLE;
        end else if (settle_inc == SETTLE_LAST) begin
          rd_accept = 1'b1;
          state_d   = ST_RD_ACTIVE;
        end
      end
      ST_RD_ACTIVE: begin
        if (!nwr_s) begin
          rd_release = 1'b1;
          coll_set   = 1'b1;
          state_d    = ST_WR_SETTLE;
        end else if (nrd_s) begin
          rd_release = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          // Count consecutive cycles on one new candidate address; falling
          // back to rd_addr or moving to another value restarts the count.
          cand_d = a_s;
          if (a_s == rd_addr_q) begin
            chg_cnt_d = 4'd0;
          end else if ((a_s != cand_q) || (chg_cnt_q == 4'd0)) begin
            chg_cnt_d = 4'd1;
          end else if (chg_cnt_q != 4'hF) begin
            chg_cnt_d = chg_cnt_q + 4'd1;
          end
          if ((a_s != rd_addr_q) && (chg_cnt_d == SETTLE_FULL)) begin
            rd_addr_d     = a_s;
            rd_cs_d       = ~ncs_s;
            rd_addr_chg_d = 1'b1;
            chg_cnt_d     = 4'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (hold_load) begin
      hold_addr_d = a_s;
      hold_data_d = d_s;
      hold_cs_d   = ~ncs_s;
    end

    if (rd_accept) begin
      rd_start_d  = 1'b1;
      rd_active_d = 1'b1;
      rd_addr_d   = a_s;
      rd_cs_d     = ~ncs_s;
      chg_cnt_d   = 4'd0;
      cand_d      = a_s;
    end

    // Leaving the read drops any address change still being qualified
    if (rd_release) begin
      rd_end_d    = 1'b1;
      rd_active_d = 1'b0;
      chg_cnt_d   = 4'd0;
    end

    if (state_d != state_q) begin
      settle_cnt_d = 4'd0;
    end

    // A set in the same cycle as err_clr wins
    err_collision_d = (err_collision_q & ~err_clr) | coll_set;
    err_glitch_d    = (err_glitch_q & ~err_clr) | glitch_set;
  end

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      nwr_sync_q      <= '1;
      nrd_sync_q      <= '1;
      ncs_sync_q      <= '1;
      a_dly_q         <= '0;
      d_dly_q         <= '0;
      state_q         <= ST_IDLE;
      settle_cnt_q    <= '0;
      chg_cnt_q       <= '0;
      cand_q          <= '0;
      hold_addr_q     <= '0;
      hold_data_q     <= '0;
      hold_cs_q       <= 1'b0;
      wr_strobe_q     <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      wr_cs_q         <= 1'b0;
      rd_start_q      <= 1'b0;
      rd_addr_chg_q   <= 1'b0;
      rd_end_q        <= 1'b0;
      rd_active_q     <= 1'b0;
      rd_addr_q       <= '0;
      rd_cs_q         <= 1'b0;
      err_collision_q <= 1'b0;
      err_glitch_q    <= 1'b0;
    end else begin
      nwr_sync_q      <= nwr_sync_d;
      nrd_sync_q      <= nrd_sync_d;
      ncs_sync_q      <= ncs_sync_d;
      a_dly_q         <= a_dly_d;
      d_dly_q         <= d_dly_d;
      state_q         <= state_d;
      settle_cnt_q    <= settle_cnt_d;
      chg_cnt_q       <= chg_cnt_d;
      cand_q          <= cand_d;
      hold_addr_q     <= hold_addr_d;
      hold_data_q     <= hold_data_d;
      hold_cs_q       <= hold_cs_d;
      wr_strobe_q     <= wr_strobe_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      wr_cs_q         <= wr_cs_d;
      rd_start_q      <= rd_start_d;
      rd_addr_chg_q   <= rd_addr_chg_d;
      rd_end_q        <= rd_end_d;
      rd_active_q     <= rd_active_d;
      rd_addr_q       <= rd_addr_d;
      rd_cs_q         <= rd_cs_d;
      err_collision_q <= err_collision_d;
      err_glitch_q    <= err_glitch_d;
    end
  end

  assign wr_strobe     = wr_strobe_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign wr_cs         = wr_cs_q;
  assign rd_start      = rd_start_q;
  assign rd_addr_chg   = rd_addr_chg_q;
  assign rd_end        = rd_end_q;
  assign rd_active     = rd_active_q;
  assign rd_addr       = rd_addr_q;
  assign rd_cs         = rd_cs_q;
  assign err_collision = err_collision_q;
  assign err_glitch    = err_glitch_q;

endmodule

// File: doc/ag32gbd_cart_bus_sync.md
# ag32gbd_cart_bus_sync

Front end for the Game Boy cartridge bus. It brings the asynchronous cart pins (A, D, nWR, nRD, nCS) into the sys_clock domain, filters glitches and turns raw pin activity into clean single-cycle events: write commit, read start, read address change and read end. Each event carries a stable captured address and data. It sits directly upstream of the ROM bank, RAM and register decoders, which consume these events instead of sampling pins themselves.

## Interface
Parameters:
- SYNC_STAGES, 2: flop stages on every control pin; minimum 2.
- SETTLE_CYCLES, 3: consecutive synced cycles a strobe or address must hold before it is accepted; range 1-15.

Ports:
- sys_clock  in  1  system clock; must be at least 8x the cart CLK.
- resetn  in  1  reset, asynchronous, active-low.
- cart_a  in  16  raw cart address pins.
- cart_d  in  8  raw cart data pins, sampled only and never driven.
- cart_nWR  in  1  raw write strobe.
- cart_nRD  in  1  raw read strobe.
- cart_nCS  in  1  raw SRAM chip select.
- err_clr  in  1  one-cycle pulse; clears the sticky error flags.
- wr_strobe  out  1  one-cycle pulse; a cart write has committed.
- wr_addr  out  16  address of the last committed write.
- wr_data  out  8  data of the last committed write.
- wr_cs  out  1  nCS was low when the last write committed.
- rd_start  out  1  one-cycle pulse; a read is accepted and rd_addr is valid.
- rd_addr_chg  out  1  one-cycle pulse; the address changed and settled while nRD stayed low.
- rd_end  out  1  one-cycle pulse; the read is released.
- rd_active  out  1  high from rd_start through rd_end.
- rd_addr  out  16  address of the current read.
- rd_cs  out  1  nCS state latched with rd_addr.
- err_collision  out  1  sticky; nWR and nRD were seen low together.
- err_glitch  out  1  sticky; a strobe was shorter than SETTLE_CYCLES.

## Operation
- **Synchronisers:** nWR, nRD and nCS each pass through SYNC_STAGES flops. A and D pass through SYNC_STAGES plain delay registers so they stay aligned with the synced controls. Every capture uses these aligned copies.
- **State machine:** IDLE, WR_SETTLE, WR_HOLD, RD_SETTLE, RD_ACTIVE. A settle counter is 4 bits wide, cleared on every state entry and saturating at 15.
- **IDLE:**
  - synced nWR low -> WR_SETTLE.
  - otherwise synced nRD low -> RD_SETTLE.
  - If both are low in the same cycle, nWR wins and err_collision is set.
- **WR_SETTLE:**
  - Counts while nWR stays low. When count reaches SETTLE_CYCLES-1 -> WR_HOLD.
  - nWR high early -> IDLE, set err_glitch, no event.
- **WR_HOLD:**
  - Every cycle, loads the aligned A, D and ~nCS into holding registers.
  - On synced nWR high -> IDLE. In that same cycle, the holding contents (last sample taken while nWR was low) go to wr_addr, wr_data and wr_cs, and wr_strobe pulses.
- **RD_SETTLE:**
  - Counts while nRD stays low. At SETTLE_CYCLES-1 -> RD_ACTIVE; rd_addr and rd_cs capture, rd_start pulses, rd_active rises.
  - nRD high early -> IDLE, set err_glitch.
- **RD_ACTIVE:**
  - Address change: when the aligned A differs from rd_addr, a change counter runs. Any cycle where A equals rd_addr or the candidate value changes resets it. After SETTLE_CYCLES stable cycles on the new value, rd_addr and rd_cs update and rd_addr_chg pulses.
  - synced nWR low -> rd_end pulses, rd_active falls, err_collision is set, then -> WR_SETTLE.
  - synced nRD high -> rd_end pulses, rd_active falls, -> IDLE. A pending address change is discarded.
- **Error flags:** err_clr clears both. A set condition in the same cycle as err_clr wins.
- **Reset:** asynchronous, so a reset mid-transfer aborts it with no event. On release the FSM is in IDLE; a strobe already low must still settle from zero.

## Timing
- Reset values: every output 0. All synchroniser and delay flops reset to 1 for nWR/nRD/nCS, and 0 for A/D.
- Read acceptance: rd_start fires SYNC_STAGES+SETTLE_CYCLES sys_clock cycles after a clean pin nRD fall (defaults: 5).
- Write commit: wr_strobe fires SYNC_STAGES+1 cycles after the pin nWR rise (defaults: 3).
- Read release: rd_end fires SYNC_STAGES+1 cycles after the pin nRD rise.
- Latched outputs: wr_addr, wr_data and wr_cs change only in the wr_strobe cycle; rd_addr and rd_cs only in the rd_start or rd_addr_chg cycle. All hold otherwise.
- Minimum accepted strobe width on the pins: SETTLE_CYCLES cycles.
- Back-to-back writes need at least 1 synced-high cycle between them.
- Every event pulse lasts exactly 1 cycle. rd_start, rd_addr_chg and rd_end are never asserted in the same cycle.

## Test plan
- **Clean write:** A=0x2000, D=0x05, nWR low for 10 cycles -> one wr_strobe 3 cycles after the rise; wr_addr=0x2000, wr_data=0x05, wr_cs=0.
- **Glitch:** nWR low for 2 cycles -> no wr_strobe; err_glitch=1. Then err_clr -> err_glitch=0.
- **Read with address change:** nRD low, nCS low, A=0xA010 for 20 cycles, then A=0xA011 for 20 cycles, then nRD high ->
  - rd_start with rd_addr=0xA010 and rd_cs=1.
  - rd_addr_chg with rd_addr=0xA011.
  - rd_end; rd_active high exactly between rd_start and rd_end.
- **Collision:** nRD and nWR fall in the same cycle, D=0x3C, both held 10 cycles -> wr_strobe with wr_data=0x3C, no rd_start, err_collision=1.
- **Reset mid-read:** drop resetn in RD_ACTIVE -> all outputs 0 immediately, no rd_end. After release, nRD still low -> rd_start after 5 cycles.
- **Noisy address:** A toggles between 0x4000 and 0x4001 every cycle for 20 cycles, nRD low -> no rd_addr_chg during toggling; exactly one rd_addr_chg once A stays at 0x4001.
